hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Consumer of the ID/EX hazard outputs (idex_mem_read, idex_rd): decides per cycle whether the pipeline advances, stalls or flushes.
//  Drives enables/flushes of PC, IF/ID, ID/EX and EX/MEM; handles load-use stalls, EX-stage mispredict flushes and data-memory wait.
//  Holds a small FSM, a pending-flush latch and saturating performance counters.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID+ID/EX flushes stay asserted after a mispredict (>=1)
//  CNT_W         32  width of perf counters
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, synchronous, active-low
//  idex_mem_read   in   1      instruction in ID/EX is a load
//  idex_rd         in   5      destination register of ID/EX instruction
//  ifid_rs1        in   5      rs1 of instruction in IF/ID
//  ifid_rs2        in   5      rs2 of instruction in IF/ID
//  ifid_use_rs1    in   1      IF/ID instruction reads rs1
//  ifid_use_rs2    in   1      IF/ID instruction reads rs2
//  ex_mispredict   in   1      branch resolved in EX disagrees with prediction (1-cycle pulse)
//  mem_req_valid   in   1      EX/MEM instruction issues a data-memory request
//  mem_ready       in   1      data memory completes request this cycle
//  pc_en           out  1      PC may update
//  ifid_en         out  1      IF/ID may load
//  idex_en         out  1      ID/EX may load
//  exmem_en        out  1      EX/MEM may load
//  ifid_flush      out  1      IF/ID loads a NOP instead of fetch data
//  idex_flush      out  1      ID/EX loads a bubble (all controls 0)
//  hcu_state       out  2      current FSM state (debug)
//  stall_cycles    out  CNT_W  cycles with pc_en==0 since reset, saturating
//  flush_events    out  CNT_W  mispredicts acted on since reset, saturating
// BEHAVIOUR
//  - Outputs combinational from registered state + inputs; state/counters/latch update on posedge clk.
//  - rst==0: state<=RUN, flush_cnt<=0, pending_flush<=0, counters<=0; outputs forced: all *_en=0, all *_flush=0.
//  - load_use = idex_mem_read & idex_rd!=0 & ((ifid_use_rs1 & rs1==idex_rd) | (ifid_use_rs2 & rs2==idex_rd)). x0 never hazards.
//  - mem_wait = mem_req_valid & !mem_ready.
//  - States: RUN=0, FLUSH=1, MEM_WAIT=2 (3 unused -> RUN next cycle, outputs as MEM_WAIT).
//  - RUN, priority mem_wait > ex_mispredict > load_use > advance:
//    mem_wait: all en=0, flushes=0; if ex_mispredict, pending_flush<=1; -> MEM_WAIT.
//    mispredict: all en=1, ifid_flush=idex_flush=1; flush_events++; if FLUSH_CYCLES>1 flush_cnt<=FLUSH_CYCLES-1, -> FLUSH.
//    load_use: pc_en=ifid_en=0, idex_en=exmem_en=1, idex_flush=1 (one bubble); stay RUN; hazard clears next cycle naturally.
//    else: all en=1, flushes=0.
//  - FLUSH: all en=1, ifid_flush=idex_flush=1; flush_cnt--; ->RUN when flush_cnt==1. mem_wait here: en=0, flushes=0, flush_cnt held, pending_flush<=1, -> MEM_WAIT. load_use ignored (IF/ID is flushed).
//  - MEM_WAIT: all en=0, flushes=0 while !mem_ready; ex_mispredict sets pending_flush.
//    On mem_ready: all en=1; if pending_flush (or current ex_mispredict): flushes=1, flush_events++, pending_flush<=0, reload flush_cnt as RUN does (FLUSH if remainder>0 else RUN); else -> RUN with flushes=0.
//  - Mispredict pulse arriving same cycle as mem_ready in MEM_WAIT counts once.
//  - stall_cycles increments every non-reset cycle with pc_en==0; both counters saturate at all-ones.
//  - Reset mid-stall/mid-flush: discards pending_flush and flush_cnt; first cycle after release is RUN.
// STRUCTURE
//  - Shared package (pipeline_pkg): state encodings HCU_RUN/HCU_FLUSH/HCU_MEM_WAIT, REG_X0=5'd0, NOP encoding 32'h00000013 (used by IF/ID).
//  - One sub-module: sat_counter (param W; inc, rst, count) instanced twice for the perf counters.
//  - FSM and hazard compare in top module.
// TESTING
//  - Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, use_rs1=1 -> one cycle pc_en=ifid_en=0, idex_flush=1; stall_cycles=1.
//  - x0 load: idex_rd=0, rs1=0 -> no stall, all en=1.
//  - Mispredict, FLUSH_CYCLES=2: pulse -> flushes=1 for 2 consecutive cycles, flush_events=1, state RUN after.
//  - Mem wait 3 cycles with mispredict pulse in cycle 2 -> en=0 for 3 cycles, flushes=1 on mem_ready cycle, flush_events=1.
//  - Priority: mem_wait+mispredict+load_use same cycle in RUN -> en=0, no flush, state MEM_WAIT, pending_flush=1.
//  - Reset (rst=0) asserted in FLUSH/MEM_WAIT -> outputs 0 during reset, RUN and counters 0 after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared pipeline definitions used by the hazard control unit and the
//   pipeline registers.
//   - hcu_state_e : encodings of the hazard control FSM (debug visible)
//   - REG_X0      : architectural zero register index
//   - NOP_INSTR   : instruction word loaded into IF/ID when it is flushed
//   - src_hazard  : true when an enabled source operand reads a non-x0 rd
// -----------------------------------------------------------------------------
package pipeline_pkg;

   typedef enum logic [1:0] {
      HCU_RUN      = 2'd0,
      HCU_FLUSH    = 2'd1,
      HCU_MEM_WAIT = 2'd2,
      HCU_RSVD     = 2'd3   // never entered normally; recovers to RUN
   } hcu_state_e;

   localparam logic [4:0]  REG_X0    = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;   // addi x0, x0, 0

   // Writes to x0 are discarded, so a load targeting x0 never creates a
   // dependency even when the consumer names x0 as a source.
   function automatic logic src_hazard(input logic       use_src,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
      return use_src && (rs == rd) && (rd != REG_X0);
   endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for performance statistics. Sticks at all-ones.
//   Ports:
//     clk   in  1  clock
//     rst   in  1  synchronous, active-low reset (clears count)
//     inc   in  1  add one this cycle
//     count out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//   Decides each cycle whether the pipeline advances, stalls or flushes.
//   Handles load-use stalls (one bubble into ID/EX), EX-stage mispredict
//   flushes (optionally stretched over FLUSH_CYCLES cycles) and data-memory
//   wait (freeze everything). A mispredict seen while memory is busy is
//   latched in pending_flush and acted on when memory completes.
//   Ports:
//     clk, rst (sync, active-low)
//     idex_mem_read, idex_rd          : load in ID/EX and its destination
//     ifid_rs1/rs2, ifid_use_rs1/rs2  : sources of the IF/ID instruction
//     ex_mispredict                   : 1-cycle pulse from branch resolution
//     mem_req_valid, mem_ready        : data-memory handshake of EX/MEM
//     pc_en, ifid_en, idex_en, exmem_en : pipeline register enables
//     ifid_flush, idex_flush          : load NOP / bubble
//     hcu_state                       : FSM state (debug)
//     stall_cycles, flush_events      : saturating perf counters
// -----------------------------------------------------------------------------
module hazard_control_unit
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             ifid_use_rs1,
   input  logic             ifid_use_rs2,
   input  logic             ex_mispredict,
   input  logic             mem_req_valid,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       hcu_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   // flush_cnt holds the remaining extra flush cycles (0 .. FLUSH_CYCLES-1).
   localparam int             FC_W      = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);

   hcu_state_e      state_q, state_d;
   logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
   logic            pending_flush_q, pending_flush_d;

   logic load_use;
   logic mem_wait;
   logic flush_inc;
   logic stall_inc;

   assign load_use = idex_mem_read &&
                     (src_hazard(ifid_use_rs1, ifid_rs1, idex_rd) ||
                      src_hazard(ifid_use_rs2, ifid_rs2, idex_rd));
   assign mem_wait = mem_req_valid && !mem_ready;

   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      pending_flush_d = pending_flush_q;
      pc_en           = 1'b0;
      ifid_en         = 1'b0;
      idex_en         = 1'b0;
      exmem_en        = 1'b0;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      flush_inc       = 1'b0;

      if (!rst) begin
         state_d         = HCU_RUN;
         flush_cnt_d     = '0;
         pending_flush_d = 1'b0;
      end else begin
         case (state_q)
            HCU_RUN: begin
               if (mem_wait) begin
                  pending_flush_d = pending_flush_q | ex_mispredict;
                  state_d         = HCU_MEM_WAIT;
               end else if (ex_mispredict) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                  {ifid_flush, idex_flush}            = 2'b11;
                  flush_inc                           = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     flush_cnt_d = FC_RELOAD;
                     state_d     = HCU_FLUSH;
                  end
               end else if (load_use) begin
                  // Hold PC and IF/ID, let the load move on and insert one
                  // bubble; next cycle the load is in EX/MEM and the
                  // hazard is gone by itself.
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  idex_flush = 1'b1;
               end else begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
               end
            end

            HCU_FLUSH: begin
               if (mem_wait) begin
                  pending_flush_d = 1'b1;
                  state_d         = HCU_MEM_WAIT;
               end else begin
                  // load_use is irrelevant: IF/ID is being flushed anyway.
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                  {ifid_flush, idex_flush}            = 2'b11;
                  flush_cnt_d                         = flush_cnt_q - FC_ONE;
                  if (flush_cnt_q <= FC_ONE) begin
                     state_d = HCU_RUN;
                  end
               end
            end

            HCU_MEM_WAIT: begin
               if (mem_ready) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
                  // A pulse coinciding with mem_ready merges with any
                  // latched one, so it is counted only once.
                  if (pending_flush_q || ex_mispredict) begin
                     {ifid_flush, idex_flush} = 2'b11;
                     flush_inc                = 1'b1;
                     pending_flush_d          = 1'b0;
                     if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FC_RELOAD;
                        state_d     = HCU_FLUSH;
                     end else begin
                        state_d = HCU_RUN;
                     end
                  end else begin
                     state_d = HCU_RUN;
                  end
               end else begin
                  pending_flush_d = pending_flush_q | ex_mispredict;
               end
            end

            default: begin
               // Unused encoding: freeze for one cycle, then resume.
               state_d = HCU_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= HCU_RUN;
         flush_cnt_q     <= '0;
         pending_flush_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         pending_flush_q <= pending_flush_d;
      end
   end

   assign stall_inc = rst && !pc_en;
   assign hcu_state = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_events)
   );

endmodule
